beverage_dispense_controller: RTL and testbench
===============================================

// Module: beverage_dispense_controller
// PURPOSE
//  Parametrised next-generation drink vending controller. Accumulates coin credit and accepts a drink selection.
//  Runs the selected drink's recipe as a timed sequence of one-hot ingredient valves, then reports change.
//  Sits between debounced front-panel inputs (coin buttons, drink switches) and the valve/display outputs.
// PARAMETERS
//  NUM_DRINKS     4         number of selectable drinks (recipe/price rows in package)
//  NUM_INGR       5         ingredient valves: 0 water,1 coffee,2 sugar,3 milk,4 chocolate
//  CREDIT_W       4         credit/change width, unit = 100 coin value
//  TICKS_PER_SEC  50000000  clock cycles per recipe second
// PORTS
//  clock        in   1                     system clock, all logic rising-edge
//  reset        in   1                     asynchronous, active-low reset
//  coin_100     in   1                     one-cycle pulse, +1 credit unit
//  coin_500     in   1                     one-cycle pulse, +5 credit units
//  drink_type   in   $clog2(NUM_DRINKS)    drink index, sampled on select
//  select       in   1                     one-cycle pulse, request drink
//  cancel       in   1                     one-cycle pulse, used only with CANCEL_REFUND_EN
//  credit       out  CREDIT_W              current accumulated credit
//  change       out  CREDIT_W              change owed after vend/refund
//  change_valid out  1                     change holds a valid amount
//  ingredient   out  NUM_INGR              valve drive, at most one bit set
//  busy         out  1                     high in DISPENSE and DONE
//  finished     out  1                     one-cycle pulse at end of vend
//  deny         out  1                     one-cycle pulse: select refused or coin rejected
// BEHAVIOUR
//  Reset value of every output is 0, and the FSM enters IDLE. Reset mid-dispense closes all valves immediately; credit is lost.
//  FSM states: IDLE -> CREDIT -> DISPENSE -> DONE -> IDLE.
//  IDLE/CREDIT:
//   - A coin adds +1/+5 the same cycle it arrives; credit is visible the next cycle.
//   - Both coins in the same cycle add +6.
//   - Sum > 2^CREDIT_W-1: credit saturates, deny pulses, and the coin is retained as-is (no refund path).
//   - The first coin clears change/change_valid and moves IDLE -> CREDIT.
//  select in CREDIT:
//   - Latches drink_type. Index >= NUM_DRINKS or credit < PRICE[drink]: deny pulses, state unchanged.
//   - Otherwise change <= credit - PRICE (registered), credit <= 0, go to DISPENSE.
//  select in IDLE: deny.
//  DISPENSE:
//   - Walks ingredients 0..NUM_INGR-1 in order, skipping entries with RECIPE[drink][i] == 0.
//   - Active valve bit is high for exactly RECIPE[drink][i]*TICKS_PER_SEC cycles.
//   - Next valve asserts the cycle after the previous one drops; there are no gap cycles.
//   - A recipe with all zeros passes straight to DONE.
//  While busy, coins are rejected (deny pulse, credit unchanged) and select/cancel are ignored.
//  DONE lasts one cycle: finished=1, change_valid=1, then IDLE. change and change_valid hold until the next coin.
//  The seconds counter restarts at 0 on each ingredient entry; there is no phase carry from a free-running tick.
//  Arithmetic is unsigned. Subtraction happens only after the credit >= PRICE check.
// CONFIGURATION
//  Macro CANCEL_REFUND_EN:
//   - Defined: cancel in CREDIT sets change <= credit, change_valid=1, credit <= 0, next IDLE. Ignored elsewhere.
//   - Undefined: cancel input is unused and credit persists until a vend or reset.
// STRUCTURE
//  Package beverage_pkg:
//   - state_t enum.
//   - PRICE[NUM_DRINKS] table (default 1,2,3,4).
//   - RECIPE[NUM_DRINKS][NUM_INGR] table, 4-bit seconds per entry.
//   - Ingredient index localparams.
//  One sub-module: ingredient_timer, a load/count-down cycle counter that pulses expire when the duration is spent.
// TESTING (bench uses TICKS_PER_SEC=4)
//  1. coin_500 then select drink 1 (price 2, recipe W2,C1) -> credit=5 then 0; water 8 cycles, coffee 4 cycles; finished; change=3.
//  2. coin_100 ×1, select drink 3 (price 4) -> deny pulse, credit stays 1, no valve asserts.
//  3. coin_100 and coin_500 in the same cycle -> credit=6; then 3× coin_500 -> credit saturates at 15, deny on the overflowing coin.
//  4. coin_500 during DISPENSE -> deny, credit 0, sequence timing unchanged.
//  5. Drop reset low on the 3rd valve cycle -> all outputs 0 asynchronously; IDLE after release.
//  6. CANCEL_REFUND_EN: coin_500+coin_100, cancel -> change=6, change_valid=1, credit=0. Without the macro: cancel has no effect.

Source files
------------

// File: rtl/beverage_pkg.sv
// rtl/beverage_pkg.sv - shared types, price and recipe tables for the drink vending controller
// Contents:
//   state_t      controller states (IDLE, CREDIT, DISPENSE, DONE)
//   PRICE        price per drink, in 100-unit credit steps
//   RECIPE       seconds per ingredient per drink (0 = ingredient skipped)
//   price_of()   bounds-checked PRICE lookup, 0 for unknown drinks
//   recipe_of()  bounds-checked RECIPE lookup, 0 outside the table
package beverage_pkg;

    localparam int PKG_NUM_DRINKS = 4;
    localparam int PKG_NUM_INGR   = 5;

    localparam int ING_WATER     = 0;
    localparam int ING_COFFEE    = 1;
    localparam int ING_SUGAR     = 2;
    localparam int ING_MILK      = 3;
    localparam int ING_CHOCOLATE = 4;

    localparam int DRW = $clog2(PKG_NUM_DRINKS);
    localparam int IRW = $clog2(PKG_NUM_INGR);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CREDIT   = 2'd1,
        S_DISPENSE = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    localparam logic [3:0] PRICE [PKG_NUM_DRINKS] = '{4'd1, 4'd2, 4'd3, 4'd4};

    // Columns: water, coffee, sugar, milk, chocolate
    localparam logic [3:0] RECIPE [PKG_NUM_DRINKS][PKG_NUM_INGR] = '{
        '{4'd3, 4'd0, 4'd0, 4'd0, 4'd0},   // hot water
        '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0},   // black coffee
        '{4'd1, 4'd1, 4'd1, 4'd2, 4'd0},   // sweet latte
        '{4'd1, 4'd0, 4'd1, 4'd1, 4'd3}    // hot chocolate
    };

    function automatic logic [3:0] price_of(input int d);
        logic [3:0] p;
        p = 4'd0;
        if (d >= 0 && d < PKG_NUM_DRINKS) begin
            p = PRICE[d[DRW-1:0]];
        end
        return p;
    endfunction

    function automatic logic [3:0] recipe_of(input int d, input int i);
        logic [3:0] r;
        r = 4'd0;
        if (d >= 0 && d < PKG_NUM_DRINKS && i >= 0 && i < PKG_NUM_INGR) begin
            r = RECIPE[d[DRW-1:0]][i[IRW-1:0]];
        end
        return r;
    endfunction

endpackage

// File: rtl/ingredient_timer.sv
// rtl/ingredient_timer.sv - load/count-down cycle counter timing one ingredient valve
// Ports:
//   clock_i   in   1      rising-edge clock
//   reset_ni  in   1      asynchronous active-low reset
//   load_i    in   1      start a new duration (takes priority over counting)
//   dur_i     in   CNT_W  duration in clock cycles; 0 leaves the timer idle
//   expire_o  out  1      high during the last cycle of the loaded duration
module ingredient_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] dur_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;

    // cnt_q holds the cycles remaining after the current one, so expire
    // lines up with the final cycle and a reload there leaves no gap.
    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (load_i) begin
            run_d = (dur_i != '0);
            cnt_d = dur_i - CNT_W'(1);
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign expire_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/beverage_dispense_controller.sv
// rtl/beverage_dispense_controller.sv - coin credit, drink selection and timed recipe valve sequencing
// Optional feature macro: CANCEL_REFUND_EN (cancel in CREDIT refunds the whole credit as change)
// Ports:
//   clock_i         in   1           rising-edge clock
//   reset_ni        in   1           asynchronous active-low reset
//   coin_100_i      in   1           pulse, +1 credit unit
//   coin_500_i      in   1           pulse, +5 credit units
//   drink_type_i    in   DT_W        drink index, sampled with select_i
//   select_i        in   1           pulse, request a drink
//   cancel_i        in   1           pulse, refund request (CANCEL_REFUND_EN only)
//   credit_o        out  CREDIT_W    accumulated credit
//   change_o        out  CREDIT_W    change owed after vend/refund
//   change_valid_o  out  1           change_o holds a valid amount
//   ingredient_o    out  NUM_INGR    one-hot valve drive
//   busy_o          out  1           dispensing or finishing
//   finished_o      out  1           pulse at end of vend
//   deny_o          out  1           pulse: select refused or coin rejected
module beverage_dispense_controller
    import beverage_pkg::*;
#(
    parameter int NUM_DRINKS    = PKG_NUM_DRINKS,
    parameter int NUM_INGR      = PKG_NUM_INGR,
    parameter int CREDIT_W      = 4,
    parameter int TICKS_PER_SEC = 50000000,
    localparam int DT_W         = (NUM_DRINKS > 1) ? $clog2(NUM_DRINKS) : 1
) (
    input  logic                clock_i,
    input  logic                reset_ni,
    input  logic                coin_100_i,
    input  logic                coin_500_i,
    input  logic [DT_W-1:0]     drink_type_i,
    input  logic                select_i,
    input  logic                cancel_i,
    output logic [CREDIT_W-1:0] credit_o,
    output logic [CREDIT_W-1:0] change_o,
    output logic                change_valid_o,
    output logic [NUM_INGR-1:0] ingredient_o,
    output logic                busy_o,
    output logic                finished_o,
    output logic                deny_o
);

    localparam int IDX_W = (NUM_INGR > 1) ? $clog2(NUM_INGR) : 1;
    localparam int CNT_W = $clog2(15 * TICKS_PER_SEC + 1);
    localparam int SUM_W = CREDIT_W + 3;
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic                change_valid_q, change_valid_d;
    logic                deny_q, deny_d;
    logic [DT_W-1:0]     drink_q, drink_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    logic                coin_any;
    logic [SUM_W-1:0]    coin_sum;
    logic                coin_ovf;
    logic                sel_ok;

    int                  lk_drink;
    int                  lk_start;
    logic                nx_found;
    logic [IDX_W-1:0]    nx_idx;
    logic [3:0]          nx_secs;

    logic                timer_load;
    logic [CNT_W-1:0]    timer_dur;
    logic                timer_expire;

    // Coin arithmetic is done wide so both coins on a full credit still
    // detect overflow instead of wrapping.
    always_comb begin
        coin_any = coin_100_i | coin_500_i;
        coin_sum = SUM_W'(credit_q) + SUM_W'(coin_100_i)
                 + (coin_500_i ? SUM_W'(5) : SUM_W'(0));
        coin_ovf = coin_sum > SUM_W'(CREDIT_MAX);
        sel_ok   = (state_q == S_CREDIT) && select_i
                 && (int'(drink_type_i) < NUM_DRINKS)
                 && (int'(credit_q) >= int'(price_of(int'(drink_type_i))));
    end

    // Next non-zero recipe step. Outside DISPENSE this finds the first step
    // of the drink being selected; inside it finds the step after idx_q.
    always_comb begin
        lk_drink = (state_q == S_DISPENSE) ? int'(drink_q) : int'(drink_type_i);
        lk_start = (state_q == S_DISPENSE) ? int'(idx_q) + 1 : 0;
        nx_found = 1'b0;
        nx_idx   = '0;
        nx_secs  = '0;
        for (int i = 0; i < NUM_INGR; i++) begin
            if (!nx_found && i >= lk_start && recipe_of(lk_drink, i) != 4'd0) begin
                nx_found = 1'b1;
                nx_idx   = IDX_W'(i);
                nx_secs  = recipe_of(lk_drink, i);
            end
        end
        timer_dur = CNT_W'(nx_secs) * CNT_W'(TICKS_PER_SEC);
    end

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        change_d       = change_q;
        change_valid_d = change_valid_q;
        deny_d         = 1'b0;
        drink_d        = drink_q;
        idx_d          = idx_q;
        timer_load     = 1'b0;

        case (state_q)
            S_IDLE, S_CREDIT: begin
                if (select_i && state_q == S_CREDIT) begin
                    drink_d = drink_type_i;
                end
                if (select_i && !sel_ok) begin
                    deny_d = 1'b1;
                end
                if (sel_ok) begin
                    change_d = credit_q - CREDIT_W'(price_of(int'(drink_type_i)));
                    credit_d = '0;
                    // A coin landing with an accepted select is not credited.
                    if (coin_any) begin
                        deny_d = 1'b1;
                    end
                    if (nx_found) begin
                        state_d    = S_DISPENSE;
                        idx_d      = nx_idx;
                        timer_load = 1'b1;
                    end else begin
                        state_d        = S_DONE;
                        change_valid_d = 1'b1;
                    end
`ifdef CANCEL_REFUND_EN
                end else if (state_q == S_CREDIT && cancel_i && !select_i) begin
                    change_d       = credit_q;
                    change_valid_d = 1'b1;
                    credit_d       = '0;
                    state_d        = S_IDLE;
                    if (coin_any) begin
                        deny_d = 1'b1;
                    end
`endif
                end else if (coin_any) begin
                    credit_d       = coin_ovf ? CREDIT_MAX : coin_sum[CREDIT_W-1:0];
                    deny_d         = deny_d | coin_ovf;
                    change_d       = '0;
                    change_valid_d = 1'b0;
                    state_d        = S_CREDIT;
                end
            end

            S_DISPENSE: begin
                if (coin_any) begin
                    deny_d = 1'b1;
                end
                if (timer_expire) begin
                    if (nx_found) begin
                        idx_d      = nx_idx;
                        timer_load = 1'b1;
                    end else begin
                        state_d        = S_DONE;
                        change_valid_d = 1'b1;
                    end
                end
            end

            S_DONE: begin
                if (coin_any) begin
                    deny_d = 1'b1;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifndef CANCEL_REFUND_EN
    logic unused_cancel;
    assign unused_cancel = cancel_i;
`endif

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            change_q       <= '0;
            change_valid_q <= 1'b0;
            deny_q         <= 1'b0;
            drink_q        <= '0;
            idx_q          <= '0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            change_q       <= change_d;
            change_valid_q <= change_valid_d;
            deny_q         <= deny_d;
            drink_q        <= drink_d;
            idx_q          <= idx_d;
        end
    end

    ingredient_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clock_i (clock_i),
        .reset_ni(reset_ni),
        .load_i  (timer_load),
        .dur_i   (timer_dur),
        .expire_o(timer_expire)
    );

    // Outputs decode straight from state so an asynchronous reset closes
    // every valve without waiting for a clock edge.
    assign credit_o       = credit_q;
    assign change_o       = change_q;
    assign change_valid_o = change_valid_q;
    assign deny_o         = deny_q;
    assign busy_o         = (state_q == S_DISPENSE) || (state_q == S_DONE);
    assign finished_o     = (state_q == S_DONE);
    assign ingredient_o   = (state_q == S_DISPENSE) ? (NUM_INGR'(1) << idx_q) : '0;

endmodule

// File: tb/tb_beverage_dispense_controller.sv
// tb/tb_beverage_dispense_controller.sv - self-checking bench for beverage_dispense_controller
module tb_beverage_dispense_controller;

    localparam int TPS = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       c100 = 1'b0;
    logic       c500 = 1'b0;
    logic [1:0] dt = 2'd0;
    logic       sel = 1'b0;
    logic       cancel = 1'b0;
    logic [3:0] credit, change;
    logic       change_valid, busy, finished, deny;
    logic [4:0] ingredient;

    always #5 clock = ~clock;

    beverage_dispense_controller #(
        .NUM_DRINKS(4), .NUM_INGR(5), .CREDIT_W(4), .TICKS_PER_SEC(TPS)
    ) dut (
        .clock_i(clock), .reset_ni(reset_n),
        .coin_100_i(c100), .coin_500_i(c500),
        .drink_type_i(dt), .select_i(sel), .cancel_i(cancel),
        .credit_o(credit), .change_o(change), .change_valid_o(change_valid),
        .ingredient_o(ingredient), .busy_o(busy), .finished_o(finished), .deny_o(deny)
    );

    int total = 0;
    int bad = 0;

    // Reference model: prices, recipes (seconds per ingredient) and money state
    int P [4] = '{1, 2, 3, 4};
    int R [4][5] = '{'{3, 0, 0, 0, 0}, '{2, 1, 0, 0, 0}, '{1, 1, 1, 2, 0}, '{1, 0, 1, 1, 3}};
    int m_credit = 0;
    int m_change = 0;
    int m_cv = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_credit"}, 32'(credit), 0);
        chk({tag, "_change"}, 32'(change), 0);
        chk({tag, "_cv"}, 32'(change_valid), 0);
        chk({tag, "_valve"}, 32'(ingredient), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_fin"}, 32'(finished), 0);
        chk({tag, "_deny"}, 32'(deny), 0);
    endtask

    task automatic coin(input bit a100, input bit a500);
        int sum;
        sum = m_credit + (a100 ? 1 : 0) + (a500 ? 5 : 0);
        c100 = a100;
        c500 = a500;
        tick();
        c100 = 1'b0;
        c500 = 1'b0;
        m_credit = (sum > 15) ? 15 : sum;
        m_change = 0;
        m_cv = 0;
        chk("coin_credit", 32'(credit), m_credit);
        chk("coin_deny", 32'(deny), (sum > 15) ? 1 : 0);
        chk("coin_cv", 32'(change_valid), 0);
        chk("coin_change", 32'(change), 0);
    endtask

    // Selects drink d; on a vend walks the expected valve timeline, injecting
    // a coin_500 at step inj (if inj lies inside the timeline).
    task automatic try_select(input int d, input int inj);
        int q[$];
        dt = d[1:0];
        sel = 1'b1;
        tick();
        sel = 1'b0;
        if (m_credit < P[d]) begin
            chk("sel_deny", 32'(deny), 1);
            chk("sel_deny_credit", 32'(credit), m_credit);
            chk("sel_deny_busy", 32'(busy), 0);
            chk("sel_deny_valve", 32'(ingredient), 0);
            return;
        end
        m_change = m_credit - P[d];
        m_credit = 0;
        chk("vend_credit", 32'(credit), 0);
        chk("vend_change", 32'(change), m_change);
        chk("vend_deny", 32'(deny), 0);
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < R[d][i] * TPS; k++) begin
                q.push_back(1 << i);
            end
        end
        for (int n = 0; n < q.size(); n++) begin
            chk("valve", 32'(ingredient), q[n]);
            chk("valve_busy", 32'(busy), 1);
            if (n == inj) c500 = 1'b1;
            tick();
            c500 = 1'b0;
            if (n == inj) begin
                chk("busy_coin_deny", 32'(deny), 1);
                chk("busy_coin_credit", 32'(credit), 0);
            end
        end
        chk("done_fin", 32'(finished), 1);
        chk("done_cv", 32'(change_valid), 1);
        chk("done_change", 32'(change), m_change);
        chk("done_valve", 32'(ingredient), 0);
        chk("done_busy", 32'(busy), 1);
        tick();
        m_cv = 1;
        chk("idle_busy", 32'(busy), 0);
        chk("idle_fin", 32'(finished), 0);
        chk("idle_cv", 32'(change_valid), m_cv);
        chk("idle_change", 32'(change), m_change);
    endtask

    initial begin
        #12;
        chk_all_zero("reset");
        #1 reset_n = 1'b1;
        tick();
        chk_all_zero("post_reset");

        // Select with no credit (IDLE) is refused
        try_select(0, -1);

        // 1. coin_500, drink 1: water 8 cycles, coffee 4, change 3
        coin(1'b0, 1'b1);
        try_select(1, -1);

        // 2. one coin_100, drink 3 too expensive; then drink 0 clears it
        coin(1'b1, 1'b0);
        try_select(3, -1);
        try_select(0, -1);

        // 3. both coins at once, then saturation
        coin(1'b1, 1'b1);
        coin(1'b0, 1'b1);
        coin(1'b0, 1'b1);
        coin(1'b0, 1'b1);
        try_select(3, -1);

        // 4. coin during dispense is denied, timeline unaffected
        coin(1'b0, 1'b1);
        try_select(2, 5);

        // 5. reset on the third valve cycle
        coin(1'b0, 1'b1);
        dt = 2'd2;
        sel = 1'b1;
        tick();
        sel = 1'b0;
        tick();
        tick();
        chk("rst_pre_valve", 32'(ingredient), 1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        #2 reset_n = 1'b1;
        tick();
        chk_all_zero("rst_release");
        m_credit = 0;
        m_change = 0;
        m_cv = 0;

        // 6. cancel after both coins
        coin(1'b1, 1'b1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
`ifdef CANCEL_REFUND_EN
        m_change = m_credit;
        m_credit = 0;
        m_cv = 1;
`endif
        chk("cancel_credit", 32'(credit), m_credit);
        chk("cancel_change", 32'(change), m_change);
        chk("cancel_cv", 32'(change_valid), m_cv);

        // Randomized coin/select traffic
        repeat (25) begin
            int ncoins;
            bit a, b;
            ncoins = $urandom_range(1, 3);
            for (int j = 0; j < ncoins; j++) begin
                a = 1'($urandom_range(0, 1));
                b = 1'($urandom_range(0, 1));
                if (!a && !b) b = 1'b1;
                coin(a, b);
            end
            try_select($urandom_range(0, 3),
                       ($urandom_range(0, 1) == 1) ? $urandom_range(0, 20) : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
